serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter: W, 16, width of the parallel pattern word (supported range 4..16).
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-high.
REQ-004 Start  input  1  request to transmit; sampled on rising Clk.
REQ-005 Data  input  W  pattern word; bits [Len-1:0] transmitted, bit Len-1 first.
REQ-006 Len  input  5  number of bits to transmit; legal 1..W.
REQ-007 Dout  output  1  registered serial bit stream, one bit per Clk cycle, feeding a 1101 Mealy detector's Din.
REQ-008 Busy  output  1  high while a bit of the pattern is being driven on Dout.
REQ-009 Done  output  1  one-cycle pulse after the last bit.
REQ-010 MatchCnt  output  4  count of overlapping "1101" occurrences in the bits transmitted since the last accepted Start.

Function
REQ-011 States: IDLE, SHIFT, DONE; encoded in a state register updated on rising Clk.
REQ-012 Start is accepted only in IDLE or DONE, and only when 1 <= Len <= W; otherwise Start is ignored and the state is unchanged.
REQ-013 On an accepted Start at edge k: capture Data and Len, clear MatchCnt and the internal pattern tracker, enter SHIFT; from edge k onward Busy=1 and Dout=Data[Len-1].
REQ-014 In SHIFT, each rising edge advances Dout to the next lower captured bit; bit i (0 = first) is on Dout during cycle k+i.
REQ-015 At edge k+Len: enter DONE; Busy=0, Done=1, Dout=0.
REQ-016 DONE lasts exactly one cycle; at the next edge return to IDLE (Done=0) unless an accepted Start moves it directly to SHIFT, giving back-to-back frames with no idle bit.
REQ-017 Start asserted in SHIFT is ignored; Data/Len changes during SHIFT have no effect on the frame in progress.
REQ-018 An internal 4-state Mealy tracker (S0, S1 "1", S11 "11", S110 "110") observes each bit as it is placed on Dout; a 1 received in S110 counts one match and moves to S1 (overlap allowed); a 0 received in S11 moves to S110; all other transitions follow the standard 1101 overlapping detector.
REQ-019 MatchCnt increments at the edge that advances past the bit completing a match, is final and stable when Done=1, holds its value in IDLE, and saturates at 15.
REQ-020 In IDLE, Dout=0, Busy=0, Done=0.

Reset
REQ-021 Rst=1 forces, without waiting for a Clk edge: state IDLE, Dout=0, Busy=0, Done=0, MatchCnt=0, tracker S0, captured registers 0.
REQ-022 Rst asserted mid-frame aborts the frame; no Done pulse is produced; after release the block waits in IDLE for a new Start.
REQ-023 Start sampled on the first edge after Rst deasserts is accepted normally.

Verification
REQ-024 Rst=1 for 30 time units with Clk period 20 -> Dout=0, Busy=0, Done=0, MatchCnt=0 throughout; no activity until Start.
REQ-025 Data=16'h000D, Len=4, one-cycle Start -> Dout 1,1,0,1 on four consecutive cycles with Busy=1; Done=1 on the fifth cycle; MatchCnt=1.
REQ-026 Data=16'h15D5, Len=14 -> Dout 0,1,0,1,0,1,1,1,0,1,0,1,0,1; MatchCnt=1 at Done; a serial_pattern_tx-driven mealy_1101 asserts Y exactly once.
REQ-027 Data=16'hDB6D, Len=16, immediately followed by Start in the DONE cycle with Data=16'h000D, Len=4 -> first frame MatchCnt=5, second frame starts with no idle gap, MatchCnt=1.
REQ-028 Start with Len=0 and Len=17 in IDLE -> ignored, Busy stays 0; Start pulsed during SHIFT -> ignored, frame length unchanged.
REQ-029 Rst asserted asynchronously between Clk edges at bit 5 of a 16-bit frame -> all outputs 0 immediately, no Done pulse, next Start transmits correctly.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts out Len bits of a captured word MSB-first and
// counts overlapping "1101" occurrences in the transmitted stream.
module serial_pattern_tx #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Start,
   input  logic [W-1:0] Data,
   input  logic [4:0]   Len,
   output logic         Dout,
   output logic         Busy,
   output logic         Done,
   output logic [3:0]   MatchCnt
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {S0, S1, S11, S110} track_t;

   state_t         state_q, state_d;
   track_t         track_q, track_d, trackNext;
   logic [W-1:0]   data_q, data_d;
   logic [IW-1:0]  bitIdx_q, bitIdx_d;
   logic           dout_q, dout_d;
   logic [3:0]     matchCnt_q, matchCnt_d;

   logic           lenOk;
   logic           hit;
   logic [IW-1:0]  firstIdx;
   logic [IW-1:0]  nextIdx;

   assign lenOk    = (Len != 5'd0) && (Len <= 5'(W));
   assign firstIdx = IW'(Len - 5'd1);
   assign nextIdx  = bitIdx_q - IW'(1);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= IDLE;
         track_q    <= S0;
         data_q     <= '0;
         bitIdx_q   <= '0;
         dout_q     <= 1'b0;
         matchCnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         track_q    <= track_d;
         data_q     <= data_d;
         bitIdx_q   <= bitIdx_d;
         dout_q     <= dout_d;
         matchCnt_q <= matchCnt_d;
      end
   end

   // The tracker consumes the bit currently on Dout, so a match is credited
   // at the edge that moves past the completing bit.
   always_comb begin
      trackNext = S0;
      hit       = 1'b0;
      case (track_q)
         S0:      trackNext = dout_q ? S1  : S0;
         S1:      trackNext = dout_q ? S11 : S0;
         S11:     trackNext = dout_q ? S11 : S110;
         S110: begin
            if (dout_q) begin
               trackNext = S1;
               hit       = 1'b1;
            end else begin
               trackNext = S0;
            end
         end
         default: trackNext = S0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      track_d    = track_q;
      data_d     = data_q;
      bitIdx_d   = bitIdx_q;
      dout_d     = dout_q;
      matchCnt_d = matchCnt_q;
      case (state_q)
         IDLE, DONE: begin
            dout_d  = 1'b0;
            state_d = IDLE;
            if (Start && lenOk) begin
               state_d    = SHIFT;
               data_d     = Data;
               bitIdx_d   = firstIdx;
               dout_d     = Data[firstIdx];
               track_d    = S0;
               matchCnt_d = 4'd0;
            end
         end
         SHIFT: begin
            track_d = trackNext;
            if (hit && (matchCnt_q != 4'd15)) begin
               matchCnt_d = matchCnt_q + 4'd1;
            end
            if (bitIdx_q == '0) begin
               state_d = DONE;
               dout_d  = 1'b0;
            end else begin
               bitIdx_d = nextIdx;
               dout_d   = data_q[nextIdx];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Dout     = dout_q;
   assign Busy     = (state_q == SHIFT);
   assign Done     = (state_q == DONE);
   assign MatchCnt = matchCnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed and random frames compared
// against a bit-list model of the transmitted stream and its "1101" count.
module tb_serial_pattern_tx;

   logic        Clk = 1'b1;
   logic        Rst = 1'b1;
   logic        Start = 1'b0;
   logic [15:0] Data = 16'h0000;
   logic [4:0]  Len = 5'd0;
   logic        Dout;
   logic        Busy;
   logic        Done;
   logic [3:0]  MatchCnt;

   int assertCount = 0;
   int failCount = 0;

   serial_pattern_tx #(.W(16)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Start    (Start),
      .Data     (Data),
      .Len      (Len),
      .Dout     (Dout),
      .Busy     (Busy),
      .Done     (Done),
      .MatchCnt (MatchCnt)
   );

   always #10 Clk = ~Clk;

   // Expected count from the transmitted bit list: every window reading 1,1,0,1.
   function automatic int expMatches(input logic [15:0] d, input int l);
      int bits[$];
      int n;
      n = 0;
      for (int i = 0; i < l; i++) bits.push_back(int'(d[l-1-i]));
      for (int j = 0; j + 3 < l; j++) begin
         if (bits[j] == 1 && bits[j+1] == 1 && bits[j+2] == 0 && bits[j+3] == 1) n++;
      end
      if (n > 15) n = 15;
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input int l);
      Data  = d;
      Len   = 5'(l);
      Start = 1'b1;
   endtask

   task automatic checkIdle(input string tag, input int expCnt);
      checkOutput({tag, " busy"}, 16'(Busy), 16'd0);
      checkOutput({tag, " done"}, 16'(Done), 16'd0);
      checkOutput({tag, " dout"}, 16'(Dout), 16'd0);
      checkOutput({tag, " cnt"}, 16'(MatchCnt), 16'(expCnt));
   endtask

   // Called at a negedge right after Start was raised; returns at the Done negedge.
   task automatic runFrame(input logic [15:0] d, input int l, input bit disturb, input string tag);
      int expCnt;
      expCnt = expMatches(d, l);
      @(negedge Clk);
      Start = 1'b0;
      for (int i = 0; i < l; i++) begin
         if (i > 0) @(negedge Clk);
         checkOutput($sformatf("%s bit%0d", tag, i), 16'(Dout), 16'(d[l-1-i]));
         checkOutput($sformatf("%s busy%0d", tag, i), 16'(Busy), 16'd1);
         checkOutput($sformatf("%s nodone%0d", tag, i), 16'(Done), 16'd0);
         if (disturb && i == 2) begin
            Data  = 16'($urandom);
            Len   = 5'($urandom_range(1, 16));
            Start = 1'b1;
         end
         if (disturb && i == 3) Start = 1'b0;
      end
      @(negedge Clk);
      checkOutput({tag, " done"}, 16'(Done), 16'd1);
      checkOutput({tag, " busyoff"}, 16'(Busy), 16'd0);
      checkOutput({tag, " doutoff"}, 16'(Dout), 16'd0);
      checkOutput({tag, " cnt"}, 16'(MatchCnt), 16'(expCnt));
   endtask

   initial begin
      logic [15:0] d;
      int          l;
      int          lastCnt;

      #5;
      checkIdle("rst t5", 0);
      #20;
      checkIdle("rst t25", 0);
      #5;
      Rst = 1'b0;
      repeat (2) begin
         @(negedge Clk);
         checkIdle("idle", 0);
      end

      applyStimulus(16'h000D, 4);
      runFrame(16'h000D, 4, 1'b0, "f000D");
      @(negedge Clk);
      checkIdle("after000D", 1);

      applyStimulus(16'h15D5, 14);
      runFrame(16'h15D5, 14, 1'b1, "f15D5");
      @(negedge Clk);
      checkIdle("after15D5", 1);

      applyStimulus(16'hFFFF, 0);
      @(negedge Clk);
      Start = 1'b0;
      checkIdle("len0", 1);
      applyStimulus(16'hFFFF, 17);
      @(negedge Clk);
      Start = 1'b0;
      checkIdle("len17", 1);

      applyStimulus(16'hDB6D, 16);
      runFrame(16'hDB6D, 16, 1'b0, "fDB6D");
      applyStimulus(16'h000D, 4);
      runFrame(16'h000D, 4, 1'b0, "chain000D");
      @(negedge Clk);
      checkIdle("afterChain", 1);

      d = 16'($urandom);
      applyStimulus(d, 16);
      @(negedge Clk);
      Start = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         if (i > 0) @(negedge Clk);
         checkOutput($sformatf("abort bit%0d", i), 16'(Dout), 16'(d[15-i]));
      end
      #3 Rst = 1'b1;
      #1;
      checkIdle("abort now", 0);
      repeat (2) begin
         @(negedge Clk);
         checkIdle("abort held", 0);
      end
      Rst = 1'b0;
      d = 16'($urandom);
      l = $urandom_range(1, 16);
      applyStimulus(d, l);
      runFrame(d, l, 1'b0, "postRst");
      lastCnt = expMatches(d, l);

      for (int k = 0; k < 8; k++) begin
         d = 16'($urandom);
         l = $urandom_range(1, 16);
         applyStimulus(d, l);
         runFrame(d, l, 1'b0, $sformatf("rnd%0d", k));
         lastCnt = expMatches(d, l);
         if ($urandom_range(0, 1) == 1) begin
            @(negedge Clk);
            checkIdle($sformatf("rndIdle%0d", k), lastCnt);
         end
      end
      @(negedge Clk);
      checkIdle("final", lastCnt);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
